// File: rtl/sram_responder.sv
// sram_responder: synchronous SRAM target for the CPU-side SRAM initiator port.
// Word array with byte-lane writes and 1-cycle registered read data (write-first).
// After reset, a clear sweep zeroes the array before accesses are honoured
// (INIT_CLEAR). Out-of-range accesses set a sticky error and capture the first
// offending address. Honoured reads and writes are counted, saturating.
// Optional: define SRAM_ERR_CLR_EN to add the err_clr input, which clears the
// captured error.
module sram_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1c000000,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
`ifdef SRAM_ERR_CLR_EN
  input  logic        err_clr,
`endif
  output logic [31:0] sram_rdata,
  output logic        ready,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] sweep_idx_q;
  logic                  ready_q;
  logic [31:0]           rdata_q;
  logic                  addr_err_q;
  logic [31:0]           err_addr_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           wr_cnt_q;

  logic [31:0]           mem [Depth];

  logic [31:0]           offset;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  access;
  logic                  rd_hit;
  logic                  wr_hit;
  logic                  oor;
  logic [31:0]           old_word;
  logic [31:0]           merged_word;
  logic                  clr_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

`ifdef SRAM_ERR_CLR_EN
  assign clr_req = err_clr;
`else
  assign clr_req = 1'b0;
`endif

  // Decode the access: range check on the wrapped offset, lane merge for writes.
  always_comb begin
    offset   = sram_addr - BASE_ADDR;
    // In range iff no offset bit at or above the byte capacity is set.
    in_range = (offset >> (ADDR_WIDTH + 2)) == 32'd0;
    word_idx = offset[ADDR_WIDTH+1:2];
    access   = (state_q == StRun) && sram_en;
    rd_hit   = access && in_range && (sram_we == 4'b0000);
    wr_hit   = access && in_range && (sram_we != 4'b0000);
    oor      = access && !in_range;
    old_word = mem[word_idx];
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sram_we[i]) merged_word[8*i +: 8] = sram_wdata[8*i +: 8];
    end
  end

  // Array write port: the clear sweep owns it in StClear, CPU writes in StRun.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = merged_word;
    if (state_q == StClear) begin
      mem_we    = INIT_CLEAR;
      mem_waddr = sweep_idx_q;
      mem_wdata = 32'h0;
    end else begin
      mem_we    = wr_hit;
    end
  end

  // Array storage; deliberately not reset so reset alone never alters contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Sweep FSM, read data, sticky error capture and saturating counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StClear;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      addr_err_q  <= 1'b0;
      err_addr_q  <= 32'h0;
      rd_cnt_q    <= 32'h0;
      wr_cnt_q    <= 32'h0;
    end else begin
      case (state_q)
        StClear: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (!INIT_CLEAR || (sweep_idx_q == '1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase

      if (rd_hit) begin
        rdata_q <= old_word;
      end else if (wr_hit) begin
        rdata_q <= merged_word;
      end else if (oor) begin
        rdata_q <= 32'h0;
      end

      if (rd_hit && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_hit && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;

      // A fault in the same cycle as a clear request wins and is captured fresh.
      if (oor) begin
        addr_err_q <= 1'b1;
        if (!addr_err_q || clr_req) err_addr_q <= sram_addr;
      end else if (clr_req) begin
        addr_err_q <= 1'b0;
        err_addr_q <= 32'h0;
      end
    end
  end

  assign sram_rdata = rdata_q;
  assign ready      = ready_q;
  assign addr_err   = addr_err_q;
  assign err_addr   = err_addr_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (ADDR_WIDTH=4, INIT_CLEAR=1). Stimulus drives
// on the falling edge and pushes the model's expected post-edge outputs; a monitor
// pops one entry after each rising edge and compares.
module tb_sram_responder;

  localparam int unsigned AW    = 4;
  localparam int unsigned Depth = 16;
  localparam logic [31:0] Base  = 32'h1c000000;
`ifdef SRAM_ERR_CLR_EN
  localparam bit HasClr = 1'b1;
`else
  localparam bit HasClr = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_we = 4'h0;
  logic [31:0] sram_addr = 32'h0;
  logic [31:0] sram_wdata = 32'h0;
`ifdef SRAM_ERR_CLR_EN
  logic        err_clr = 1'b0;
`endif
  logic [31:0] sram_rdata;
  logic        ready;
  logic        addr_err;
  logic [31:0] err_addr;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  sram_responder #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (Base),
    .INIT_CLEAR (1'b1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
`ifdef SRAM_ERR_CLR_EN
    .err_clr    (err_clr),
`endif
    .sram_rdata (sram_rdata),
    .ready      (ready),
    .addr_err   (addr_err),
    .err_addr   (err_addr),
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        rdy;
    logic        err;
    logic [31:0] eaddr;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Reference model state.
  logic [31:0] m_mem [Depth];
  int          m_clear_left;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] m_eaddr;
  logic [31:0] m_rd;
  logic [31:0] m_wr;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < Depth; i++) m_mem[i] = 32'h0;
    m_clear_left = Depth;
    m_rdata = 32'h0;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    m_rd    = 32'h0;
    m_wr    = 32'h0;
  endfunction

  // Effect of one clock edge with the given inputs, then queue the expected outputs.
  function automatic void model_step(input logic en, input logic [3:0] we,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     input logic clr);
    logic [31:0] off;
    logic        fault;
    int          idx;
    exp_t        e;
    fault = 1'b0;
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (en) begin
      off = addr - Base;
      if (off < 4 * Depth) begin
        idx = int'(off / 4);
        if (we == 4'h0) begin
          m_rdata = m_mem[idx];
          if (m_rd != 32'hFFFF_FFFF) m_rd++;
        end else begin
          for (int b = 0; b < 4; b++) if (we[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
          m_rdata = m_mem[idx];
          if (m_wr != 32'hFFFF_FFFF) m_wr++;
        end
      end else begin
        fault = 1'b1;
        m_rdata = 32'h0;
      end
    end
    if (fault) begin
      if (!m_err || clr) m_eaddr = addr;
      m_err = 1'b1;
    end else if (clr) begin
      m_err   = 1'b0;
      m_eaddr = 32'h0;
    end
    e.rdata = m_rdata;
    e.rdy   = (m_clear_left == 0);
    e.err   = m_err;
    e.eaddr = m_eaddr;
    e.rd    = m_rd;
    e.wr    = m_wr;
    exp_q.push_back(e);
  endfunction

  // Entered and left on a falling edge.
  task automatic cyc(input logic en, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic clr);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wd;
`ifdef SRAM_ERR_CLR_EN
    err_clr    = clr;
`endif
    model_step(en, we, addr, wd, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    sram_en = 1'b0;
    sram_we = 4'h0;
`ifdef SRAM_ERR_CLR_EN
    err_clr = 1'b0;
`endif
    #1;
    chk("rst_rdata", sram_rdata, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_rd_cnt", rd_cnt, 32'h0);
    chk("rst_wr_cnt", wr_cnt, 32'h0);
    model_reset();
    @(negedge clk);
  endtask

  task automatic random_traffic(input int n);
    logic        en;
    logic [3:0]  we;
    logic [31:0] a;
    logic [31:0] d;
    logic        c;
    for (int k = 0; k < n; k++) begin
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      a  = ($urandom_range(0, 7) == 0) ? $urandom() : Base + $urandom_range(0, 63);
      d  = $urandom();
      c  = HasClr && ($urandom_range(0, 15) == 0);
      cyc(en, we, a, d, c);
    end
  endtask

  // Monitor: compare DUT outputs after every rising edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", sram_rdata, e.rdata);
        chk("ready", {31'b0, ready}, {31'b0, e.rdy});
        chk("addr_err", {31'b0, addr_err}, {31'b0, e.err});
        chk("err_addr", err_addr, e.eaddr);
        chk("rd_cnt", rd_cnt, e.rd);
        chk("wr_cnt", wr_cnt, e.wr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    do_reset();
    resetn = 1'b1;
    // Clear sweep: the read in the middle must be ignored.
    for (int i = 0; i < Depth; i++) begin
      if (i == 3) cyc(1'b1, 4'h0, 32'h1c000008, 32'h0, 1'b0);
      else        cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    end
    // Directed RUN sequence.
    cyc(1'b1, 4'h0, 32'h1c000008, 32'h0, 1'b0);
    cyc(1'b1, 4'hF, 32'h1c000010, 32'h12345678, 1'b0);
    cyc(1'b1, 4'b0010, 32'h1c000010, 32'h0000AB00, 1'b0);
    cyc(1'b1, 4'h0, 32'h1c000010, 32'h0, 1'b0);
    cyc(1'b1, 4'hF, 32'h1c000040, 32'hDEADBEEF, 1'b0);
    cyc(1'b1, 4'h0, 32'h00000000, 32'h0, 1'b0);
    cyc(1'b1, 4'h0, 32'h1c000000, 32'h0, 1'b0);
    cyc(1'b1, 4'hF, 32'h1c000004, 32'hCAFEF00D, 1'b0);
    cyc(1'b1, 4'h0, 32'h1c000004, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, 4'h0, 32'h1c000008, 32'h0, 1'b0);
    chk("hold_rdata", sram_rdata, 32'hCAFEF00D);
    chk("first_err_addr", err_addr, 32'h1c000040);
    chk("dir_rd_cnt", rd_cnt, 32'd4);
    chk("dir_wr_cnt", wr_cnt, 32'd3);

    random_traffic(200);

    // Reset in RUN, then again at sweep index 7.
    do_reset();
    resetn = 1'b1;
    repeat (7) cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    do_reset();
    resetn = 1'b1;
    repeat (Depth) cyc(1'b1, 4'h0, 32'h1c000004, 32'h0, 1'b0);
    cyc(1'b1, 4'h0, 32'h1c000004, 32'h0, 1'b0);
    chk("swept_word", sram_rdata, 32'h0);
    random_traffic(60);

    cyc(1'b1, 4'h0, 32'h1c000100, 32'h0, 1'b0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b1 & HasClr);
    if (HasClr) begin
      chk("clr_addr_err", {31'b0, addr_err}, 32'h0);
      chk("clr_err_addr", err_addr, 32'h0);
      cyc(1'b1, 4'h0, 32'h1c000200, 32'h0, 1'b0);
      cyc(1'b1, 4'h0, 32'h20000000, 32'h0, 1'b1);
      chk("clr_vs_fault", err_addr, 32'h20000000);
    end else begin
      chk("sticky_err", {31'b0, addr_err}, 32'h1);
    end
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
